// File: rtl/acc_result_fifo.sv
// acc_result_fifo: result capture FIFO behind the 8-bit accumulator.
// Stores {carry, sum} words with valid/ready on both sides, first-word
// fall-through on the read side, a saturating carry-out counter and a
// sticky drop flag for results offered while the FIFO was full.
module acc_result_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             ck,
    input  logic             clr,
    input  logic [WIDTH-1:0] s_in,
    input  logic             co_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH:0]   out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW:0]      count,
    output logic [7:0]       ovf_cnt,
    output logic             drop,
    input  logic             clr_stat
);

    localparam int unsigned DW = WIDTH + 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } occ_t;

    occ_t            state;
    occ_t            state_nxt;

    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr_nxt;
    logic [AW-1:0]   rd_ptr_nxt;
    logic [CW-1:0]   count_nxt;
    logic [DW-1:0]   head_nxt;
    logic [DW-1:0]   wr_data;
    logic [7:0]      ovf_nxt;
    logic            drop_nxt;
    logic            in_ready_nxt;
    logic            out_valid_nxt;
    logic            push;
    logic            pop;

    // Next-state, pointer, occupancy and registered-output computation
    always_comb begin
        push          = in_valid & in_ready;
        pop           = out_valid & out_ready;
        wr_data       = {co_in, s_in};
        wr_ptr_nxt    = wr_ptr;
        rd_ptr_nxt    = rd_ptr;
        count_nxt     = count;
        state_nxt     = state;
        head_nxt      = '0;
        ovf_nxt       = ovf_cnt;
        drop_nxt      = drop;
        in_ready_nxt  = 1'b1;
        out_valid_nxt = 1'b0;

        if (push) begin
            wr_ptr_nxt = wr_ptr + AW'(1);
        end
        if (pop) begin
            rd_ptr_nxt = rd_ptr + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase

        // Occupancy FSM: only a lone push or lone pop moves between states
        case (state)
            ST_EMPTY: begin
                if (push) begin
                    state_nxt = ST_PARTIAL;
                end
            end
            ST_PARTIAL: begin
                if (push && !pop && (count == CW'(DEPTH - 1))) begin
                    state_nxt = ST_FULL;
                end else if (pop && !push && (count == CW'(1))) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop && !push) begin
                    state_nxt = ST_PARTIAL;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase

        in_ready_nxt  = (state_nxt != ST_FULL);
        out_valid_nxt = (state_nxt != ST_EMPTY);

        // Head word after this edge; bypass when it is the word being written
        if (state_nxt == ST_EMPTY) begin
            head_nxt = '0;
        end else if (push && (rd_ptr_nxt == wr_ptr)) begin
            head_nxt = wr_data;
        end else begin
            head_nxt = mem[rd_ptr_nxt];
        end

        if (clr_stat) begin
            ovf_nxt = '0;
        end else if (push && co_in && (ovf_cnt != 8'hFF)) begin
            ovf_nxt = ovf_cnt + 8'd1;
        end

        if (clr_stat) begin
            drop_nxt = 1'b0;
        end else if (in_valid && !in_ready) begin
            drop_nxt = 1'b1;
        end
    end

    // Storage array, intentionally without reset
    always_ff @(posedge ck) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // State, pointers, statistics and registered outputs
    always_ff @(posedge ck or negedge clr) begin
        if (!clr) begin
            state     <= ST_EMPTY;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            ovf_cnt   <= '0;
            drop      <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= head_nxt;
            ovf_cnt   <= ovf_nxt;
            drop      <= drop_nxt;
        end
    end

endmodule

// File: tb/tb_acc_result_fifo.sv
// Bench for acc_result_fifo: queue-based reference model plus directed
// and randomized scenarios.
module tb_acc_result_fifo;

    localparam int DEPTH = 4;

    logic       ck;
    logic       clr;
    logic [7:0] s_in;
    logic       co_in;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;
    logic [7:0] ovf_cnt;
    logic       drop;
    logic       clr_stat;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [8:0] q[$];
    int         m_ovf;
    bit         m_drop;
    bit         m_ready;

    acc_result_fifo #(.WIDTH(8), .DEPTH(DEPTH), .AW(2)) dut (
        .ck        (ck),
        .clr       (clr),
        .s_in      (s_in),
        .co_in     (co_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .ovf_cnt   (ovf_cnt),
        .drop      (drop),
        .clr_stat  (clr_stat)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // model response to one clock edge, from the current inputs
    function automatic void model_edge();
        bit do_push;
        bit do_pop;
        do_push = in_valid && m_ready;
        do_pop  = (q.size() != 0) && out_ready;
        if (clr_stat) begin
            m_ovf  = 0;
            m_drop = 0;
        end else begin
            if (do_push && co_in && m_ovf < 255) m_ovf++;
            if (in_valid && !m_ready) m_drop = 1;
        end
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back({co_in, s_in});
        m_ready = (q.size() < DEPTH);
    endfunction

    function automatic logic [8:0] exp_head();
        if (q.size() == 0) return 9'h000;
        return q[0];
    endfunction

    function automatic void model_reset();
        q.delete();
        m_ovf   = 0;
        m_drop  = 0;
        m_ready = 0;
    endfunction

    task automatic tick();
        @(posedge ck);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b0; s_in = '0; co_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_stat = 1'b0;
        model_reset();
        repeat (2) @(posedge ck);
        #1;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL reset_hold: count=%0d out_valid=%b in_ready=%b want 0/0/0", count, out_valid, in_ready); end
        #3 clr = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b want 0", in_ready); end
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release: got %b want 1", in_ready); end
        in_valid = 1'b1; co_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_in = 8'($urandom);
            tick();
        end
        in_valid = 1'b0; co_in = 1'b0;
        checks++; if (count !== 3'd3 || ovf_cnt !== 8'(m_ovf)) begin errors++; $display("FAIL pre_reset_fill: count=%0d ovf=%0d want 3/%0d", count, ovf_cnt, m_ovf); end
        #3 clr = 1'b0;
        model_reset();
        #1;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 9'h000 || ovf_cnt !== 8'd0 || drop !== 1'b0) begin
            errors++; $display("FAIL async_reset: count=%0d out_valid=%b out_data=%h ovf=%0d drop=%b want all 0", count, out_valid, out_data, ovf_cnt, drop);
        end
        #2 clr = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL post_reset: in_ready=%b count=%0d want 1/0", in_ready, count); end
    endtask

    task automatic test_order();
        logic [7:0] sv [3];
        logic       cv [3];
        logic [8:0] want [3];
        sv[0] = 8'h05; cv[0] = 1'b0; want[0] = 9'h005;
        sv[1] = 8'hFF; cv[1] = 1'b1; want[1] = 9'h1FF;
        sv[2] = 8'h10; cv[2] = 1'b0; want[2] = 9'h010;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_in = sv[i]; co_in = cv[i];
            tick();
        end
        in_valid = 1'b0; co_in = 1'b0;
        checks++; if (count !== 3'd3 || count !== 3'(q.size())) begin errors++; $display("FAIL order_count: got %0d want 3", count); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== want[i] || out_data !== exp_head()) begin
                errors++; $display("FAIL order_data[%0d]: valid=%b data=%h want 1/%h", i, out_valid, out_data, want[i]);
            end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || count !== 3'd0 || out_data !== 9'h000) begin
            errors++; $display("FAIL order_empty: valid=%b count=%0d data=%h want 0/0/000", out_valid, count, out_data);
        end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            s_in = 8'($urandom_range(0, 8'hA9)); co_in = 1'($urandom);
            tick();
        end
        s_in = 8'hAA; co_in = 1'b0;
        repeat (3) tick();
        checks++; if (in_ready !== 1'b0 || count !== 3'd4 || drop !== 1'b1 || drop !== m_drop) begin
            errors++; $display("FAIL full_block: in_ready=%b count=%0d drop=%b want 0/4/1", in_ready, count, drop);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (out_data !== exp_head() || out_data[7:0] === 8'hAA) begin
                errors++; $display("FAIL full_drain[%0d]: got %h want %h", i, out_data, exp_head());
            end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (count !== 3'd0 || drop !== 1'b1) begin errors++; $display("FAIL full_after: count=%0d drop=%b want 0/1", count, drop); end
        clr_stat = 1'b1;
        tick();
        clr_stat = 1'b0;
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL drop_clear: got %b want 0", drop); end
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_in = 8'($urandom); co_in = 1'($urandom);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_in = 8'($urandom); co_in = 1'($urandom);
            checks++; if (out_data !== exp_head()) begin errors++; $display("FAIL simul_data[%0d]: got %h want %h", i, out_data, exp_head()); end
            tick();
            checks++; if (count !== 3'd2) begin errors++; $display("FAIL simul_count[%0d]: got %0d want 2", i, count); end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (out_data !== exp_head()) begin errors++; $display("FAIL simul_drain[%0d]: got %h want %h", i, out_data, exp_head()); end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL simul_empty: count=%0d valid=%b want 0/0", count, out_valid); end
    endtask

    task automatic test_overflow_stats();
        clr_stat = 1'b1;
        tick();
        clr_stat = 1'b0;
        in_valid = 1'b1; co_in = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            s_in = 8'($urandom);
            tick();
            if (i == 99) begin
                checks++; if (ovf_cnt !== 8'd100) begin errors++; $display("FAIL ovf_mid: got %0d want 100", ovf_cnt); end
            end
        end
        checks++; if (ovf_cnt !== 8'd255 || ovf_cnt !== 8'(m_ovf)) begin errors++; $display("FAIL ovf_sat: got %0d want 255", ovf_cnt); end
        clr_stat = 1'b1;
        tick();
        clr_stat = 1'b0;
        checks++; if (ovf_cnt !== 8'd0) begin errors++; $display("FAIL ovf_clear_wins: got %0d want 0", ovf_cnt); end
        in_valid = 1'b0; co_in = 1'b0;
        repeat (DEPTH) tick();
        out_ready = 1'b0;
        checks++; if (count !== 3'd0 || ovf_cnt !== 8'd0 || drop !== 1'b0) begin
            errors++; $display("FAIL ovf_after: count=%0d ovf=%0d drop=%b want 0/0/0", count, ovf_cnt, drop);
        end
    endtask

    task automatic test_fall_through();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_data !== 9'h000) begin errors++; $display("FAIL ft_empty: valid=%b data=%h want 0/000", out_valid, out_data); end
        s_in = 8'h3C; co_in = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 9'h03C) begin errors++; $display("FAIL ft_latency: valid=%b data=%h want 1/03c", out_valid, out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL ft_pop: valid=%b count=%0d want 0/0", out_valid, count); end
    endtask

    task automatic test_random();
        int in_pct;
        int out_pct;
        for (int i = 0; i < 600; i++) begin
            in_pct  = (i < 300) ? 75 : 30;
            out_pct = (i < 300) ? 35 : 80;
            in_valid  = ($urandom_range(0, 99) < in_pct);
            out_ready = ($urandom_range(0, 99) < out_pct);
            clr_stat  = ($urandom_range(0, 99) < 3);
            s_in      = 8'($urandom);
            co_in     = 1'($urandom);
            tick();
            checks++; if (count !== 3'(q.size())) begin errors++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, count, q.size()); end
            checks++; if (out_data !== exp_head() || out_valid !== (q.size() != 0)) begin
                errors++; $display("FAIL rnd_head[%0d]: data=%h valid=%b want %h/%b", i, out_data, out_valid, exp_head(), q.size() != 0);
            end
            checks++; if (in_ready !== m_ready) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, in_ready, m_ready); end
            checks++; if (ovf_cnt !== 8'(m_ovf) || drop !== m_drop) begin
                errors++; $display("FAIL rnd_stats[%0d]: ovf=%0d drop=%b want %0d/%b", i, ovf_cnt, drop, m_ovf, m_drop);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0; clr_stat = 1'b0;
    endtask

    initial begin
        test_reset();
        test_order();
        test_full();
        test_simultaneous();
        test_overflow_stats();
        test_fall_through();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
